spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//  Byte-framed register bank behind the SPI_SLAVE user interface (DOUT/DOUT_VLD in, DIN/DIN_VLD/READY out).
//  Decodes a command byte {RW, ADDR[6:0]} followed by DATA_BYTES data bytes (MSB first) per register word.
//  Writes update a parametrised register file; reads stream a register back to the master.
//  Successor to the single-byte LED latch: top drives leds from REGS[7:0] (register 0, low byte).
// PARAMETERS
//  NUM_REGS    4      number of registers, 1..128
//  DATA_BYTES  1      bytes per register word, 1..4 (word width DW = 8*DATA_BYTES)
//  RST_BYTE    8'hFF  reset value, replicated into every byte of every register
// PORTS
//  CLK      in   1                   system clock (24 MHz)
//  RST      in   1                   synchronous reset, active-high
//  CS_N     in   1                   SPI chip select pin (async); frame boundary only
//  RX_DATA  in   8                   byte from SPI_SLAVE DOUT
//  RX_VLD   in   1                   1-cycle strobe from SPI_SLAVE DOUT_VLD
//  TX_DATA  out  8                   byte for next transfer, to SPI_SLAVE DIN
//  TX_VLD   out  1                   to SPI_SLAVE DIN_VLD
//  TX_READY in   1                   SPI_SLAVE READY; TX_DATA sampled when TX_VLD & TX_READY
//  REGS     out  NUM_REGS*DW         flattened register file, reg i at [i*DW +: DW]
//  WR_STB   out  1                   1-cycle pulse on register commit
//  WR_ADDR  out  7                   address of last commit, held until next commit
//  ERR_CNT  out  8                   saturating protocol-error count
// BEHAVIOUR
//  Reset: REGS = RST_BYTE replicated; TX_DATA=8'h00; TX_VLD=0; WR_STB=0; WR_ADDR=0; ERR_CNT=0; FSM=ST_CMD.
//  TX_VLD = 1 in every non-reset cycle. TX_DATA changes only in the cycle after RX_VLD or after frame end.
//  CS_N: 2-FF synchronised; frame end = rising edge of synced CS_N (2-3 CLK latency).
//  FSM states / transitions (on RX_VLD unless noted):
//   ST_CMD  : latch addr=RX_DATA[6:0], byte_idx=0; RX_DATA[7]=0 -> ST_WDATA, =1 -> ST_RDATA.
//   ST_WDATA: shift byte into word buffer, byte_idx++; on byte_idx==DATA_BYTES-1 -> commit, next state per ADDR rule.
//   ST_RDATA: byte_idx++ per byte clocked out; after last byte -> next state per ADDR rule.
//   ST_SKIP : bytes ignored; TX_DATA=8'h00.
//   Frame end from any state -> ST_CMD, byte_idx=0, word buffer cleared.
//  Commit: REGS[addr] and WR_STB=1 in the cycle after the last byte's RX_VLD; WR_ADDR=addr same cycle.
//  Read: read word snapshotted on command byte; TX_DATA = byte DATA_BYTES-1-byte_idx of snapshot, set the
//   cycle after each RX_VLD, so the first read byte appears on the transfer following the command byte.
//   Master must leave >=4 CLK between bytes so TX_DATA settles before SPI_SLAVE READY load.
//  Non-read states: TX_DATA=8'h00 after each byte.
//  Address >= NUM_REGS: write dropped (no WR_STB), read returns 8'hFF bytes; ERR_CNT+1 once per command.
//  Frame end in ST_WDATA with byte_idx!=0: partial word discarded, no commit, ERR_CNT+1.
//  Simultaneous RX_VLD and frame end: byte processed first (commit if it completes a word), then ST_CMD.
//  ERR_CNT saturates at 8'hFF. RST mid-frame: full reset, REGS reinitialised, partial word lost.
// CONFIGURATION
//  SPI_REG_AUTOINC_EN defined: after a word completes, addr <= (addr==NUM_REGS-1) ? 0 : addr+1, byte_idx=0,
//   stay in ST_WDATA/ST_RDATA (burst access, wraps at NUM_REGS-1 -> 0).
//  Not defined: after a word completes -> ST_SKIP until frame end; extra bytes ignored, TX_DATA=8'h00.
// STRUCTURE
//  Shared include spi_reg_defs.vh: state encodings ST_CMD/ST_WDATA/ST_RDATA/ST_SKIP, CMD_RW_BIT=7,
//   TX_IDLE=8'h00, TX_BAD=8'hFF, ADDR_W=7.
//  Sub-module sync_2ff (CS_N synchroniser, reset value 1); everything else in this module.
// TESTING
//  1 Reset, no frames -> REGS all 8'hFF, TX_DATA=8'h00, ERR_CNT=0, TX_VLD=1 after RST drops.
//  2 Frame {8'h01, 8'h3C} (DATA_BYTES=1) -> REGS[15:8]=8'h3C, one WR_STB, WR_ADDR=1, leds unchanged.
//  3 Frame {8'h81, 8'h00} after test 2 -> second byte's MISO = 8'h3C; no WR_STB.
//  4 DATA_BYTES=2: frame {8'h02, 8'hAB} then CS_N high -> no commit, ERR_CNT=1, REGS[2] stays 16'hFFFF.
//  5 NUM_REGS=4: frame {8'h85, 8'h00} -> reply 8'hFF, ERR_CNT+1; write {8'h05,8'h11} -> no WR_STB.
//  6 AUTOINC_EN, NUM_REGS=4: {8'h03,8'h01,8'h02} -> reg3=8'h01, reg0=8'h02 (wrap), 2 WR_STB;
//    without macro -> reg3=8'h01 only, reg0 unchanged.

Source files
------------

// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the SPI register bank: FSM states, command layout, idle/bad reply bytes.
package spi_reg_bank_pkg;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned IDX_W      = 2;
  localparam logic [7:0]  TX_IDLE    = 8'h00;
  localparam logic [7:0]  TX_BAD     = 8'hFF;

  typedef enum logic [1:0] {
    ST_CMD   = 2'd0,
    ST_WDATA = 2'd1,
    ST_RDATA = 2'd2,
    ST_SKIP  = 2'd3
  } state_e;

  // Byte sel of a word of up to four bytes (sel 0 is the least significant byte).
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [IDX_W-1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/spi_reg_bank_sync_2ff.sv
// Two-flop synchroniser for the asynchronous chip-select pin; resets to the idle (high) level.
module spi_reg_bank_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// Byte-framed register bank behind an SPI slave byte interface.
// Define SPI_REG_AUTOINC_EN for burst access with address auto-increment (wraps at NUM_REGS-1).
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned DATA_BYTES = 1,
  parameter logic [7:0]  RST_BYTE   = 8'hFF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CS_N,
  input  logic [7:0]                 RX_DATA,
  input  logic                       RX_VLD,
  output logic [7:0]                 TX_DATA,
  output logic                       TX_VLD,
  input  logic                       TX_READY,
  output logic [NUM_REGS*8*DATA_BYTES-1:0] REGS,
  output logic                       WR_STB,
  output logic [ADDR_W-1:0]          WR_ADDR,
  output logic [7:0]                 ERR_CNT,
  output logic [7:0]                 LEDS
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  byte_idx;
  logic [DW-1:0]     wbuf;
  logic [DW-1:0]     snap;
  logic [DW-1:0]     regs_q [NUM_REGS];
  logic              cs_s;
  logic              cs_d;

  // TX_DATA is always presented, so the slave's load handshake needs no tracking.
  logic unused_ready;
  assign unused_ready = TX_READY;

  spi_reg_bank_sync_2ff u_cs_sync (
    .clk (CLK),
    .rst (RST),
    .d   (CS_N),
    .q   (cs_s)
  );

  logic          frame_end_c;
  logic          cmd_ok_c;
  logic          addr_ok_c;
  logic [DW-1:0] cmd_word_c;
  logic [DW-1:0] wword_c;
  logic          partial_c;
  logic          err_inc_c;

  assign frame_end_c = cs_s & ~cs_d;
  assign cmd_ok_c    = 32'(RX_DATA[ADDR_W-1:0]) < NUM_REGS;
  assign addr_ok_c   = 32'(addr) < NUM_REGS;
  assign cmd_word_c  = cmd_ok_c ? regs_q[AW'(RX_DATA[ADDR_W-1:0])] : {DATA_BYTES{TX_BAD}};
  assign wword_c     = DW'({wbuf, RX_DATA});
  // A byte arriving with frame end is counted first, so only a still-unfinished word is an error.
  assign partial_c   = (state == ST_WDATA) &&
                       (RX_VLD ? (byte_idx != LAST_IDX) : (byte_idx != '0));
  assign err_inc_c   = (RX_VLD && (state == ST_CMD) && !cmd_ok_c) || (frame_end_c && partial_c);

`ifdef SPI_REG_AUTOINC_EN
  logic [ADDR_W-1:0] next_addr_c;
  logic [DW-1:0]     next_word_c;
  assign next_addr_c = (32'(addr) == NUM_REGS - 1) ? '0 : addr + ADDR_W'(1);
  assign next_word_c = (32'(next_addr_c) < NUM_REGS) ? regs_q[AW'(next_addr_c)]
                                                      : {DATA_BYTES{TX_BAD}};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= {DATA_BYTES{RST_BYTE}};
      state    <= ST_CMD;
      addr     <= '0;
      byte_idx <= '0;
      wbuf     <= '0;
      snap     <= '0;
      cs_d     <= 1'b1;
      TX_DATA  <= TX_IDLE;
      TX_VLD   <= 1'b0;
      WR_STB   <= 1'b0;
      WR_ADDR  <= '0;
      ERR_CNT  <= '0;
    end else begin
      TX_VLD <= 1'b1;
      WR_STB <= 1'b0;
      cs_d   <= cs_s;
      if (err_inc_c && (ERR_CNT != 8'hFF)) ERR_CNT <= ERR_CNT + 8'd1;

      if (RX_VLD) begin
        case (state)
          ST_CMD: begin
            addr     <= RX_DATA[ADDR_W-1:0];
            byte_idx <= '0;
            if (RX_DATA[CMD_RW_BIT]) begin
              state   <= ST_RDATA;
              snap    <= cmd_word_c;
              TX_DATA <= byte_of(32'(cmd_word_c), LAST_IDX);
            end else begin
              state   <= ST_WDATA;
              TX_DATA <= TX_IDLE;
            end
          end
          ST_WDATA: begin
            TX_DATA <= TX_IDLE;
            if (byte_idx == LAST_IDX) begin
              wbuf     <= '0;
              byte_idx <= '0;
              if (addr_ok_c) begin
                regs_q[AW'(addr)] <= wword_c;
                WR_STB            <= 1'b1;
                WR_ADDR           <= addr;
              end
`ifdef SPI_REG_AUTOINC_EN
              addr <= next_addr_c;
`else
              state <= ST_SKIP;
`endif
            end else begin
              wbuf     <= wword_c;
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
          ST_RDATA: begin
            if (byte_idx == LAST_IDX) begin
              byte_idx <= '0;
`ifdef SPI_REG_AUTOINC_EN
              addr    <= next_addr_c;
              snap    <= next_word_c;
              TX_DATA <= byte_of(32'(next_word_c), LAST_IDX);
`else
              state   <= ST_SKIP;
              TX_DATA <= TX_IDLE;
`endif
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              TX_DATA  <= byte_of(32'(snap), LAST_IDX - byte_idx - IDX_W'(1));
            end
          end
          default: TX_DATA <= TX_IDLE;
        endcase
      end

      // Frame end overrides the byte's state update but keeps any commit it made.
      if (frame_end_c) begin
        state    <= ST_CMD;
        byte_idx <= '0;
        wbuf     <= '0;
        TX_DATA  <= TX_IDLE;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign REGS[g*DW +: DW] = regs_q[g];
  end

  assign LEDS = regs_q[0][7:0];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench: one bank with 1-byte words (a) and one with 2-byte words (b), four registers each.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_a = 1'b1, cs_b = 1'b1;
  logic [7:0]  rxd_a = 8'h00, rxd_b = 8'h00;
  logic        rxv_a = 1'b0, rxv_b = 1'b0;
  logic        ready = 1'b1;

  logic [7:0]  txd_a, txd_b;
  logic        txv_a, txv_b;
  logic [31:0] regs_a;
  logic [63:0] regs_b;
  logic        stb_a, stb_b;
  logic [6:0]  wa_a, wa_b;
  logic [7:0]  err_a, err_b;
  logic [7:0]  leds_a, leds_b;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_cnt_a = 0;
  int stb_cnt_b = 0;

  always #5 clk = ~clk;

  spi_reg_bank #(.NUM_REGS(4), .DATA_BYTES(1), .RST_BYTE(8'hFF)) u_dut_a (
    .CLK(clk), .RST(rst), .CS_N(cs_a), .RX_DATA(rxd_a), .RX_VLD(rxv_a),
    .TX_DATA(txd_a), .TX_VLD(txv_a), .TX_READY(ready), .REGS(regs_a),
    .WR_STB(stb_a), .WR_ADDR(wa_a), .ERR_CNT(err_a), .LEDS(leds_a)
  );

  spi_reg_bank #(.NUM_REGS(4), .DATA_BYTES(2), .RST_BYTE(8'hFF)) u_dut_b (
    .CLK(clk), .RST(rst), .CS_N(cs_b), .RX_DATA(rxd_b), .RX_VLD(rxv_b),
    .TX_DATA(txd_b), .TX_VLD(txv_b), .TX_READY(ready), .REGS(regs_b),
    .WR_STB(stb_b), .WR_ADDR(wa_b), .ERR_CNT(err_b), .LEDS(leds_b)
  );

  always @(posedge clk) begin
    if (rst) begin
      stb_cnt_a <= 0;
      stb_cnt_b <= 0;
    end else begin
      if (stb_a) stb_cnt_a <= stb_cnt_a + 1;
      if (stb_b) stb_cnt_b <= stb_cnt_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel_b, input logic [7:0] b);
    @(posedge clk); #1;
    if (sel_b) begin rxd_b = b; rxv_b = 1'b1; end
    else       begin rxd_a = b; rxv_a = 1'b1; end
    @(posedge clk); #1;
    rxv_a = 1'b0;
    rxv_b = 1'b0;
    cycles(4);
  endtask

  task automatic frame_start(input bit sel_b);
    if (sel_b) cs_b = 1'b0; else cs_a = 1'b0;
    cycles(4);
  endtask

  task automatic frame_end(input bit sel_b);
    if (sel_b) cs_b = 1'b1; else cs_a = 1'b1;
    cycles(6);
  endtask

  initial begin
    // Reset state
    cycles(3);
    chk("txv_in_reset", 64'(txv_a), 64'd0);
    rst = 1'b0;
    cycles(1);
    chk("txv_after_reset", 64'(txv_a), 64'd1);
    chk("regs_a_reset", 64'(regs_a), 64'hFFFF_FFFF);
    chk("regs_b_reset", regs_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("txd_a_reset", 64'(txd_a), 64'h00);
    chk("err_a_reset", 64'(err_a), 64'd0);
    chk("wa_a_reset", 64'(wa_a), 64'd0);

    // Write 0x3C to register 1
    frame_start(0); send(0, 8'h01); send(0, 8'h3C); frame_end(0);
    chk("wr1_regs", 64'(regs_a), 64'hFFFF_3CFF);
    chk("wr1_stb", 64'(stb_cnt_a), 64'd1);
    chk("wr1_addr", 64'(wa_a), 64'd1);
    chk("wr1_leds", 64'(leds_a), 64'hFF);

    // Read register 1 back
    frame_start(0); send(0, 8'h81);
    chk("rd1_miso", 64'(txd_a), 64'h3C);
    send(0, 8'h00);
`ifdef SPI_REG_AUTOINC_EN
    chk("rd1_after_word", 64'(txd_a), 64'hFF);
`else
    chk("rd1_after_word", 64'(txd_a), 64'h00);
`endif
    frame_end(0);
    chk("rd1_no_stb", 64'(stb_cnt_a), 64'd1);
    chk("rd1_idle_tx", 64'(txd_a), 64'h00);

    // Two-byte words: partial write dropped, full write and read
    frame_start(1); send(1, 8'h02); send(1, 8'hAB); frame_end(1);
    chk("part_err", 64'(err_b), 64'd1);
    chk("part_reg2", 64'(regs_b[47:32]), 64'hFFFF);
    chk("part_no_stb", 64'(stb_cnt_b), 64'd0);
    frame_start(1); send(1, 8'h03); send(1, 8'h12); send(1, 8'h34); frame_end(1);
    chk("w16_reg3", 64'(regs_b[63:48]), 64'h1234);
    chk("w16_stb", 64'(stb_cnt_b), 64'd1);
    chk("w16_err", 64'(err_b), 64'd1);
    frame_start(1); send(1, 8'h83);
    chk("r16_msb", 64'(txd_b), 64'h12);
    send(1, 8'h00);
    chk("r16_lsb", 64'(txd_b), 64'h34);
    frame_end(1);

    // Out-of-range address
    frame_start(0); send(0, 8'h85);
    chk("bad_rd_miso", 64'(txd_a), 64'hFF);
    send(0, 8'h00); frame_end(0);
    chk("bad_rd_err", 64'(err_a), 64'd1);
    frame_start(0); send(0, 8'h05); send(0, 8'h11); frame_end(0);
    chk("bad_wr_stb", 64'(stb_cnt_a), 64'd1);
    chk("bad_wr_err", 64'(err_a), 64'd2);
    chk("bad_wr_regs", 64'(regs_a), 64'hFFFF_3CFF);

    // Burst at the last register
    frame_start(0); send(0, 8'h03); send(0, 8'h01); send(0, 8'h02); frame_end(0);
`ifdef SPI_REG_AUTOINC_EN
    chk("burst_regs", 64'(regs_a), 64'h01FF_3C02);
    chk("burst_stb", 64'(stb_cnt_a), 64'd3);
    chk("burst_addr", 64'(wa_a), 64'd0);
    chk("burst_leds", 64'(leds_a), 64'h02);
`else
    chk("burst_regs", 64'(regs_a), 64'h01FF_3CFF);
    chk("burst_stb", 64'(stb_cnt_a), 64'd2);
    chk("burst_addr", 64'(wa_a), 64'd3);
    chk("burst_leds", 64'(leds_a), 64'hFF);
`endif
    chk("burst_err", 64'(err_a), 64'd2);

    // Reset in the middle of a frame
    frame_start(1); send(1, 8'h01); send(1, 8'h55);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cs_b = 1'b1;
    cycles(6);
    chk("midrst_regs_b", regs_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midrst_err_b", 64'(err_b), 64'd0);
    chk("midrst_stb_b", 64'(stb_cnt_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
